// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential PC generation, one-cycle-latency imem reads, DEPTH-entry
// {pc, instr} FIFO to decode. Optional macro FETCHQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_L   = (AW+2)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};

    logic [31:0]   pc_r;
    logic          inflight_r;
    logic [31:0]   inflight_pc_r;
    logic [63:0]   mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW:0]   count_r;

    logic [AW+1:0] occ_s;
    logic          req_s;
    logic          resp_s;
    logic          push_s;
    logic          pop_s;
    logic          valid_s;
    logic [63:0]   head_s;
    logic [31:0]   instr_s;
    logic [31:0]   pc_s;

    assign head_s = mem_r[rd_ptr_r];

    // Credit check counts the in-flight read so a returning word always has a free slot.
    always_comb begin
        occ_s  = {1'b0, count_r} + {{(AW+1){1'b0}}, inflight_r};
        req_s  = 1'b0;
        resp_s = 1'b0;
        if (rstn_i && !redirect_i && (occ_s < DEPTH_L)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        if (inflight_r && !redirect_i) begin
            resp_s = 1'b1;
        end else begin
            resp_s = 1'b0;
        end
    end

`ifdef FETCHQ_BYPASS_EN
    logic byp_s;

    // Empty queue: present the returning word directly; store it only if decode stalls.
    always_comb begin
        byp_s   = resp_s && (count_r == CNT_ZERO);
        valid_s = (count_r != CNT_ZERO) || byp_s;
        pop_s   = (count_r != CNT_ZERO) && ready_i;
        if (byp_s) begin
            instr_s = imem_data_i;
            pc_s    = inflight_pc_r;
            push_s  = !ready_i;
        end else begin
            instr_s = head_s[31:0];
            pc_s    = head_s[63:32];
            push_s  = resp_s;
        end
    end
`else
    // Outputs come only from stored entries; no path from imem_data_i to decode.
    always_comb begin
        valid_s = (count_r != CNT_ZERO);
        pop_s   = valid_s && ready_i;
        push_s  = resp_s;
        instr_s = head_s[31:0];
        pc_s    = head_s[63:32];
    end
`endif

    assign imem_req_o  = req_s;
    assign imem_addr_o = pc_r;
    assign valid_o     = valid_s;
    assign instr_o     = instr_s;
    assign pc_o        = pc_s;

    // Fetch PC, in-flight tracking and FIFO state; redirect outranks every other update.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            rd_ptr_r      <= {AW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            count_r       <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {64{1'b0}};
            end
        end else if (redirect_i) begin
            pc_r       <= redirect_pc_i;
            inflight_r <= 1'b0;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= CNT_ZERO;
        end else begin
            inflight_r <= req_s;
            if (req_s) begin
                pc_r          <= pc_r + 32'd4;
                inflight_pc_r <= pc_r;
            end else begin
                pc_r          <= pc_r;
                inflight_pc_r <= inflight_pc_r;
            end
            if (push_s) begin
                mem_r[wr_ptr_r] <= {inflight_pc_r, imem_data_i};
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a bench memory answers reads one cycle later and expected
// {pc, instr} pairs are queued when each response is driven, then compared at every decode handshake.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i = 32'hDEAD_BEEF;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0000_0000;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q [$];
    logic [31:0] pop_log [$];
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] key = 32'h0000_0000;
    logic        req_s;
    logic        valid_s;
    logic [31:0] addr_s;
    logic [31:0] req_pc_s;
    int          cyc = 0;
    int          n_req = 0;
    int          n_pop = 0;
    int          first_valid = -1;

`ifdef FETCHQ_BYPASS_EN
    localparam int FILL = 1;
`else
    localparam int FILL = 2;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: sample outputs on the falling edge, then answer the read just after the rising edge.
    task automatic step();
        logic [63:0] e;
        @(negedge clk_i);
        cyc++;
        req_s   = imem_req_o;
        valid_s = valid_o;
        addr_s  = imem_addr_o;
        if (redirect_i) check_eq("req_during_redirect", {63'd0, imem_req_o}, 64'd0);
        if (imem_req_o) begin
            check_eq("req_addr", {32'd0, imem_addr_o}, {32'd0, model_pc});
            req_pc_s = model_pc;
            model_pc = model_pc + 32'd4;
            n_req++;
        end
        if (valid_o && ready_i) begin
            check_eq("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("pop_pc_instr", {pc_o, instr_o}, e);
                pop_log.push_back(pc_o);
            end
            n_pop++;
        end
        if (redirect_i) begin
            exp_q.delete();
            pop_log.delete();
            model_pc = redirect_pc_i;
        end
        @(posedge clk_i);
        #1;
        if (req_s) begin
            imem_data_i = addr_s ^ key;
            exp_q.push_back({req_pc_s, req_pc_s ^ key});
        end else begin
            imem_data_i = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_reset();
        rstn_i     = 1'b0;
        ready_i    = 1'b0;
        redirect_i = 1'b0;
        step();
        step();
        exp_q.delete();
        pop_log.delete();
        model_pc = RESET_PC;
        n_req = 0;
        n_pop = 0;
        rstn_i = 1'b1;
        cyc = -1;
    endtask

    initial begin
        // Reset state with no clock edge since time zero.
        #1;
        check_eq("rst_valid", {63'd0, valid_o}, 64'd0);
        check_eq("rst_req", {63'd0, imem_req_o}, 64'd0);
        check_eq("rst_addr", {32'd0, imem_addr_o}, {32'd0, RESET_PC});
        check_eq("rst_pc_instr", {pc_o, instr_o}, 64'd0);

        // Streaming with ready high, address-as-data.
        key = 32'h0000_0000;
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid_s && first_valid < 0) first_valid = cyc;
        end
        check_eq("first_valid_cycle", 64'(first_valid), 64'(FILL));
        check_eq("stream_pops", 64'(n_pop), 64'(20 - FILL));
        check_eq("stream_first_pc", {63'd0, pop_log.size() >= 3}, 64'd1);
        if (pop_log.size() >= 3) check_eq("stream_pc2", {32'd0, pop_log[2]}, 64'h8);

        // Decode stalled: credit stops requests at DEPTH.
        key = 32'h5A5A_0000;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check_eq("stall_nreq", 64'(n_req), 64'd4);
        check_eq("stall_req_low", {63'd0, req_s}, 64'd0);
        check_eq("stall_valid", {63'd0, valid_s}, 64'd1);
        ready_i = 1'b1;
        step();
        check_eq("resume_pop_cycle_req", {63'd0, req_s}, 64'd0);
        step();
        check_eq("resume_next_req", {63'd0, req_s}, 64'd1);
        for (int i = 0; i < 10; i++) step();
        check_eq("stall_order_size", {63'd0, pop_log.size() >= 4}, 64'd1);
        if (pop_log.size() >= 4) check_eq("stall_order", {pop_log[0], pop_log[3]}, {32'h0, 32'hC});

        // Redirect with 3 queued entries, one read in flight, and a pop in the same cycle.
        key = 32'h0F0F_F0F0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        ready_i = 1'b1;
        step();
        redirect_i = 1'b0;
        redirect_pc_i = 32'h1357_9BDF;
        step();
        check_eq("redir_valid_r1", {63'd0, valid_s}, 64'd0);
        check_eq("redir_req_r1", {63'd0, req_s}, 64'd1);
        step();
        check_eq("redir_valid_r2", {63'd0, valid_s}, 64'(FILL == 1));
        step();
        check_eq("redir_valid_r3", {63'd0, valid_s}, 64'd1);
        for (int i = 0; i < 4; i++) step();
        check_eq("redir_log_size", {63'd0, pop_log.size() >= 2}, 64'd1);
        if (pop_log.size() >= 2) check_eq("redir_pcs", {pop_log[0], pop_log[1]}, {32'h100, 32'h104});

        // Redirect in steady state: pop and response coincide with it.
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        step();
        redirect_i = 1'b0;
        step();
        check_eq("redir2_valid_r1", {63'd0, valid_s}, 64'd0);
        for (int i = 0; i < 5; i++) step();
        check_eq("redir2_log_size", {63'd0, pop_log.size() >= 1}, 64'd1);
        if (pop_log.size() >= 1) check_eq("redir2_pc", {32'd0, pop_log[0]}, 64'h200);

        // PC wraps past the top of the address space.
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        step();
        redirect_i = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check_eq("wrap_log_size", {63'd0, pop_log.size() >= 3}, 64'd1);
        if (pop_log.size() >= 3) begin
            check_eq("wrap_pc01", {pop_log[0], pop_log[1]}, {32'hFFFF_FFF8, 32'hFFFF_FFFC});
            check_eq("wrap_pc2", {32'd0, pop_log[2]}, 64'h0);
        end

        // Asynchronous reset while the queue is full.
        ready_i = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check_eq("full_valid", {63'd0, valid_s}, 64'd1);
        rstn_i = 1'b0;
        #1;
        check_eq("async_valid", {63'd0, valid_o}, 64'd0);
        check_eq("async_req", {63'd0, imem_req_o}, 64'd0);
        check_eq("async_addr", {32'd0, imem_addr_o}, {32'd0, RESET_PC});
        check_eq("async_pc_instr", {pc_o, instr_o}, 64'd0);
        key = 32'hC3C3_3C3C;
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check_eq("restart_log_size", {63'd0, pop_log.size() >= 2}, 64'd1);
        if (pop_log.size() >= 2) check_eq("restart_pcs", {pop_log[0], pop_log[1]}, {RESET_PC, RESET_PC + 32'd4});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage directly upstream of the decoder. Generates the sequential fetch PC and issues requests to a synchronous instruction memory with one-cycle read latency. Buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake. A redirect from execute flushes the queue, discards any in-flight read, and restarts fetch at a new PC.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  clock, all state on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- imem_req_o  out  1  read request this cycle
- imem_addr_o  out  32  read address (= pc_q)
- imem_data_i  in  32  read data, valid the cycle after a request
- redirect_i  in  1  flush and restart fetch
- redirect_pc_i  in  32  restart address
- valid_o  out  1  head entry valid for decode
- ready_i  in  1  decode accepts head entry
- instr_o  out  32  head instruction (to decoder instruction_i)
- pc_o  out  32  PC of head instruction

## Operation
- State: pc_q (32), inflight_q (1), inflight_pc_q (32), FIFO storage DEPTH×64, rd/wr pointers, count_q (log2(DEPTH)+1 bits).
- Credit rule: imem_req_o = !redirect_i && (count_q + inflight_q < DEPTH). Never overflows; no full-push case exists.
- On request: inflight_q←1, inflight_pc_q←pc_q, pc_q←pc_q+4 (mod 2^32, wraps from 0xFFFF_FFFC to 0).
- Response: when inflight_q=1 and no redirect, {inflight_pc_q, imem_data_i} pushed at wr pointer; inflight_q←0 unless a new request issued.
- Pop: valid_o && ready_i advances rd pointer. Simultaneous push and pop leave count_q unchanged.
- valid_o = (count_q≠0). instr_o/pc_o = head entry; values undefined-but-stable when valid_o=0.
- Redirect (highest priority): pc_q←redirect_pc_i; count_q, pointers, inflight_q←0; pending response and any pop this cycle are discarded (pop still consumes, irrelevant since queue cleared). No request that cycle; fetch resumes at redirect_pc_i next cycle.
- redirect_pc_i low two bits are used as given; alignment is the sender's responsibility.
- Reset (async, any time): pc_q←RESET_PC, inflight_q←0, count_q←0, pointers←0, storage←0. While rstn_i low: imem_req_o=0, valid_o=0, imem_addr_o=RESET_PC, instr_o=0, pc_o=0.

## Timing
- First request in the first clock edge after rstn_i rises (cycle 0) at RESET_PC.
- Request in cycle N → data at imem_data_i in N+1 → entry written at end of N+1 → valid_o in N+2 (without bypass).
- Steady state with ready_i=1: one instruction per cycle after initial 2-cycle fill.
- Redirect in cycle R: valid_o=0 in R+1, request at redirect_pc_i in R+1, first valid_o in R+3 (R+2 with bypass).
- ready_i held low: requests stop once count_q+inflight_q=DEPTH; resume the cycle after a pop.

## Configuration
- FETCHQ_BYPASS_EN defined: when count_q=0 and a response arrives (no redirect), valid_o=1 combinationally with instr_o=imem_data_i, pc_o=inflight_pc_q in that cycle; if ready_i=1 the word is consumed and not written, else it is pushed. Fill latency drops to 1 cycle.
- Undefined: no combinational path from imem_data_i to outputs; latency as in Timing.

## Test plan
- Reset release, ready_i=1, memory returns addr-as-data: imem_addr_o 0x0,0x4,0x8…; valid_o first high cycle 2 (cycle 1 with bypass), pc_o/instr_o 0x0, then one per cycle.
- ready_i=0 for 10 cycles after reset: exactly DEPTH=4 requests issued, count_q=4, imem_req_o low; raise ready_i → entries 0x0..0xC delivered in order, requests resume.
- Redirect to 0x100 while queue holds 3 entries and one read in flight: valid_o low next cycle, stale data never appears, next pc_o = 0x100, then 0x104.
- Redirect in same cycle as pop and response: no entry from before redirect emerges; count_q=0 next cycle.
- redirect_pc_i=0xFFFF_FFF8: pc_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert rstn_i low mid-stream with full queue: valid_o and imem_req_o drop immediately (no clock); after release fetch restarts at RESET_PC.
